// File: rtl/wallace_pipe.sv
// Pipelined Wallace-tree reduction of C_NUM_PP partial products to a carry-save pair,
// with ready/valid flow control, bubble collapsing, flush and a dropped-carry-MSB flag.
module wallace_pipe #(
    parameter int C_WIDTH       = 49,
    parameter int C_NUM_PP      = 13,
    parameter int C_PIPE_STAGES = 2,
    parameter int C_TAG_WIDTH   = 4
) (
    input  logic                              Clk_CI,
    input  logic                              Rst_RBI,
    input  logic [C_NUM_PP-1:0][C_WIDTH-1:0]  Pp_index_DI,
    input  logic [C_TAG_WIDTH-1:0]            Tag_DI,
    input  logic                              In_valid_SI,
    output logic                              In_ready_SO,
    input  logic                              Flush_SI,
    output logic [C_WIDTH-1:0]                Pp_sum_DO,
    output logic [C_WIDTH-1:0]                Pp_carry_DO,
    output logic                              MSB_cor_DO,
    output logic [C_TAG_WIDTH-1:0]            Tag_DO,
    output logic                              Out_valid_SO,
    input  logic                              Out_ready_SI
);

    function automatic int rows_after(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int num_levels(input int n);
        int l = 0;
        int r = n;
        while (r > 2) begin
            r = rows_after(r);
            l++;
        end
        return l;
    endfunction

    function automatic int rows_at(input int lv);
        int r = C_NUM_PP;
        for (int i = 0; i < lv; i++) r = rows_after(r);
        return r;
    endfunction

    localparam int L = num_levels(C_NUM_PP);
    localparam int S = C_PIPE_STAGES;

    // Returns the stage index whose register sits right after level lv, or 0.
    function automatic int stage_of(input int lv);
        for (int k = 1; k <= S; k++)
            if ((k * L + S - 1) / S == lv) return k;
        return 0;
    endfunction

    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int N  = rows_at(l - 1);
        localparam int NO = rows_at(l);
        localparam int K  = stage_of(l - 1);

        logic [N-1:0][C_WIDTH-1:0]  w_src;
        logic                       w_src_msb;
        logic [NO-1:0][C_WIDTH-1:0] w_rows;
        logic                       w_msb;

        if (l == 1) begin : g_src_in
            assign w_src     = Pp_index_DI;
            assign w_src_msb = 1'b0;
        end else if (K > 0) begin : g_src_reg
            assign w_src     = g_stg[K].r_rows;
            assign w_src_msb = g_stg[K].r_msb;
        end else begin : g_src_comb
            assign w_src     = g_lvl[l-1].w_rows;
            assign w_src_msb = g_lvl[l-1].w_msb;
        end

        always_comb begin
            logic [C_WIDTH-1:0] w_cy;
            w_cy   = '0;
            w_rows = '0;
            w_msb  = w_src_msb;
            for (int g = 0; g < N / 3; g++) begin
                w_rows[2*g] = w_src[3*g] ^ w_src[3*g+1] ^ w_src[3*g+2];
                w_cy = (w_src[3*g] & w_src[3*g+1]) | (w_src[3*g] & w_src[3*g+2])
                     | (w_src[3*g+1] & w_src[3*g+2]);
                // Carry weight doubles; its top bit falls off the result width.
                w_rows[2*g+1] = {w_cy[C_WIDTH-2:0], 1'b0};
                w_msb = w_msb | w_cy[C_WIDTH-1];
            end
            for (int j = 0; j < N % 3; j++)
                w_rows[2*(N/3)+j] = w_src[3*(N/3)+j];
        end
    end

    for (genvar k = 1; k <= S; k++) begin : g_stg
        localparam int B  = (k * L + S - 1) / S;
        localparam int NR = rows_at(B);

        logic [NR-1:0][C_WIDTH-1:0] r_rows;
        logic                       r_msb;
        logic [C_TAG_WIDTH-1:0]     r_tag;
        logic                       r_vld;
        logic                       w_load;
        logic                       w_in_vld;
        logic [C_TAG_WIDTH-1:0]     w_in_tag;

        // A full stage still loads when its occupant moves on the same edge.
        if (k == S) begin : g_last
            assign w_load = !r_vld || Out_ready_SI;
        end else begin : g_mid
            assign w_load = !r_vld || g_stg[k+1].w_load;
        end

        if (k == 1) begin : g_first
            assign w_in_vld = In_valid_SI && In_ready_SO;
            assign w_in_tag = Tag_DI;
        end else begin : g_next
            assign w_in_vld = g_stg[k-1].r_vld;
            assign w_in_tag = g_stg[k-1].r_tag;
        end

        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                r_vld <= 1'b0;
            end else if (Flush_SI) begin
                r_vld <= 1'b0;
            end else if (w_load) begin
                r_vld <= w_in_vld;
            end
        end

        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                r_rows <= '0;
                r_msb  <= 1'b0;
                r_tag  <= '0;
            end else if (w_load && w_in_vld) begin
                r_rows <= g_lvl[B].w_rows;
                r_msb  <= g_lvl[B].w_msb;
                r_tag  <= w_in_tag;
            end
        end
    end

    assign In_ready_SO  = g_stg[1].w_load && !Flush_SI;
    assign Pp_sum_DO    = g_stg[S].r_rows[0];
    assign Pp_carry_DO  = g_stg[S].r_rows[1];
    assign MSB_cor_DO   = g_stg[S].r_msb;
    assign Tag_DO       = g_stg[S].r_tag;
    assign Out_valid_SO = g_stg[S].r_vld;

endmodule

// File: tb/tb_wallace_pipe.sv
// Directed checks of wallace_pipe: default config plus a 3-row, 1-stage instance.
module tb_wallace_pipe;
    localparam int W  = 49;
    localparam int NP = 13;
    localparam int W3 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0][W-1:0] pp;
    logic [3:0] tag_i, tag_o;
    logic in_valid, in_ready, flush, out_valid, out_ready, msb;
    logic [W-1:0] sum, carry, tot;

    logic [2:0][W3-1:0] pp3;
    logic [3:0] tag3_i, tag3_o;
    logic in_valid3, in_ready3, out_valid3, out_ready3, msb3;
    logic [W3-1:0] sum3, carry3;

    int checks = 0;
    int failures = 0;

    wallace_pipe dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Pp_index_DI(pp), .Tag_DI(tag_i),
        .In_valid_SI(in_valid), .In_ready_SO(in_ready), .Flush_SI(flush),
        .Pp_sum_DO(sum), .Pp_carry_DO(carry), .MSB_cor_DO(msb), .Tag_DO(tag_o),
        .Out_valid_SO(out_valid), .Out_ready_SI(out_ready)
    );

    wallace_pipe #(.C_WIDTH(W3), .C_NUM_PP(3), .C_PIPE_STAGES(1), .C_TAG_WIDTH(4)) dut3 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Pp_index_DI(pp3), .Tag_DI(tag3_i),
        .In_valid_SI(in_valid3), .In_ready_SO(in_ready3), .Flush_SI(1'b0),
        .Pp_sum_DO(sum3), .Pp_carry_DO(carry3), .MSB_cor_DO(msb3), .Tag_DO(tag3_o),
        .Out_valid_SO(out_valid3), .Out_ready_SI(out_ready3)
    );

    assign tot = sum + carry;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] p0, input logic [3:0] t);
        in_valid = v;
        pp = '0;
        pp[0] = p0;
        tag_i = t;
    endtask

    task automatic test_reset;
        #2;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        if (sum !== '0) begin failures++; $display("FAIL rst_sum got %0h want 0", sum); end
        if (carry !== '0) begin failures++; $display("FAIL rst_carry got %0h want 0", carry); end
        if (msb !== 1'b0) begin failures++; $display("FAIL rst_msb got %0b want 0", msb); end
        if (tag_o !== 4'd0) begin failures++; $display("FAIL rst_tag got %0d want 0", tag_o); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic;
        in_valid = 1'b1;
        for (int i = 0; i < NP; i++) pp[i] = 49'd1;
        tag_i = 4'd3;
        tick;
        drive(1'b0, '0, 4'd0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early got %0b want 0", out_valid); end
        tick;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        if (tot !== 49'd13) begin failures++; $display("FAIL basic_sum got %0d want 13", tot); end
        if (msb !== 1'b0) begin failures++; $display("FAIL basic_msb got %0b want 0", msb); end
        if (tag_o !== 4'd3) begin failures++; $display("FAIL basic_tag got %0d want 3", tag_o); end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (c >= 2 && c <= 6) begin
                if (out_valid !== 1'b1 || tot !== 49'(c - 2) || tag_o !== 4'(c - 2)) begin
                    failures++;
                    $display("FAIL b2b_out c=%0d got v=%0b s=%0d t=%0d want v=1 s=%0d", c, out_valid, tot, tag_o, c - 2);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle c=%0d got %0b want 0", c, out_valid);
            end
            if (c < 5) begin
                drive(1'b1, 49'(c), 4'(c));
                #1;
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got %0b want 1", c, in_ready); end
            end else drive(1'b0, '0, 4'd0);
            tick;
        end
    endtask

    task automatic test_stall;
        int n_acc = 0;
        int j = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 49'(10 + j), 4'(j));
            #1;
            if (in_ready) begin n_acc++; j++; end
            tick;
        end
        drive(1'b0, '0, 4'd0);
        #1;
        checks += 4;
        if (n_acc != 2) begin failures++; $display("FAIL stall_accepted got %0d want 2", n_acc); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got %0b want 0", in_ready); end
        if (out_valid !== 1'b1 || tot !== 49'd10) begin failures++; $display("FAIL stall_out got v=%0b s=%0d want v=1 s=10", out_valid, tot); end
        if (tag_o !== 4'd0) begin failures++; $display("FAIL stall_tag got %0d want 0", tag_o); end
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b1 || tot !== 49'd10 || tag_o !== 4'd0) begin
            failures++; $display("FAIL stall_hold got v=%0b s=%0d t=%0d want v=1 s=10 t=0", out_valid, tot, tag_o);
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b1 || tot !== 49'd11 || tag_o !== 4'd1) begin
            failures++; $display("FAIL stall_drain got v=%0b s=%0d t=%0d want v=1 s=11 t=1", out_valid, tot, tag_o);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush;
        drive(1'b1, 49'd20, 4'd5);
        tick;
        drive(1'b1, 49'd21, 4'd6);
        tick;
        drive(1'b1, 49'd99, 4'd7);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %0b want 0", in_ready); end
        tick;
        flush = 1'b0;
        drive(1'b0, '0, 4'd0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost c=%0d got %0b want 0", c, out_valid); end
        end
        drive(1'b1, 49'd30, 4'd8);
        tick;
        drive(1'b0, '0, 4'd0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_lat1 got %0b want 0", out_valid); end
        tick;
        checks++;
        if (out_valid !== 1'b1 || tot !== 49'd30 || tag_o !== 4'd8) begin
            failures++; $display("FAIL flush_next got v=%0b s=%0d t=%0d want v=1 s=30 t=8", out_valid, tot, tag_o);
        end
        tick;
    endtask

    task automatic test_msb;
        logic [W3-1:0] vec [3][3];
        logic [W3-1:0] es [3];
        logic [W3-1:0] ec [3];
        logic em [3];
        vec[0] = '{8'h80, 8'h80, 8'h80}; es[0] = 8'h80; ec[0] = 8'h00; em[0] = 1'b1;
        vec[1] = '{8'h01, 8'h02, 8'h04}; es[1] = 8'h07; ec[1] = 8'h00; em[1] = 1'b0;
        vec[2] = '{8'h03, 8'h03, 8'h03}; es[2] = 8'h03; ec[2] = 8'h06; em[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1;
            for (int r = 0; r < 3; r++) pp3[r] = vec[i][r];
            tag3_i = 4'(9 + i);
            tick;
            in_valid3 = 1'b0;
            checks++;
            if (out_valid3 !== 1'b1 || sum3 !== es[i] || carry3 !== ec[i] || msb3 !== em[i] || tag3_o !== 4'(9 + i)) begin
                failures++;
                $display("FAIL msb_vec%0d got v=%0b s=%0h c=%0h m=%0b t=%0d want v=1 s=%0h c=%0h m=%0b t=%0d",
                         i, out_valid3, sum3, carry3, msb3, tag3_o, es[i], ec[i], em[i], 9 + i);
            end
            tick;
            checks++;
            if (out_valid3 !== 1'b0) begin failures++; $display("FAIL msb_drain%0d got %0b want 0", i, out_valid3); end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 49'd40, 4'd10);
        tick;
        drive(1'b1, 49'd41, 4'd11);
        tick;
        drive(1'b0, '0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        if (sum !== '0 || carry !== '0) begin failures++; $display("FAIL arst_data got s=%0h c=%0h want 0", sum, carry); end
        if (tag_o !== 4'd0) begin failures++; $display("FAIL arst_tag got %0d want 0", tag_o); end
        if (msb !== 1'b0) begin failures++; $display("FAIL arst_msb got %0b want 0", msb); end
        tick;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_ghost c=%0d got %0b want 0", c, out_valid); end
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got %0b want 1", in_ready); end
    endtask

    initial begin
        pp = '0; tag_i = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pp3 = '0; tag3_i = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_flush;
        test_msb;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wallace_pipe.md
WALLACE_PIPE -- requirements
Module: wallace_pipe

Interface
REQ-001 The block SHALL take parameter C_WIDTH, default 49 (2*C_MANT+3), giving the partial-product and result width in bits.
REQ-002 The block SHALL take parameter C_NUM_PP, default 13, legal range 3..32, giving the number of partial products reduced.
REQ-003 The block SHALL take parameter C_PIPE_STAGES, default 2, legal range 1..L, where L is the number of 3:2 reduction levels needed for C_NUM_PP operands.
REQ-004 The block SHALL take parameter C_TAG_WIDTH, default 4, giving the width of the sideband tag carried alongside each operation.
REQ-005 Clk_CI  in  1  single clock; all state changes on the rising edge.
REQ-006 Rst_RBI  in  1  asynchronous, active-low reset.
REQ-007 Pp_index_DI  in  [C_NUM_PP-1:0][C_WIDTH-1:0]  partial products.
REQ-008 Tag_DI  in  C_TAG_WIDTH  sideband tag accepted with the operands.
REQ-009 In_valid_SI  in  1  operands and tag are valid.
REQ-010 In_ready_SO  out  1  block accepts an input this cycle.
REQ-011 Flush_SI  in  1  synchronous discard of all in-flight operations.
REQ-012 Pp_sum_DO  out  C_WIDTH  carry-save sum vector.
REQ-013 Pp_carry_DO  out  C_WIDTH  carry-save carry vector, already left-aligned (shifted by one).
REQ-014 MSB_cor_DO  out  1  at least one carry MSB was discarded during reduction.
REQ-015 Tag_DO  out  C_TAG_WIDTH  tag of the operation currently at the output.
REQ-016 Out_valid_SO  out  1  outputs are valid.
REQ-017 Out_ready_SI  in  1  downstream accepts the output.

Function
REQ-018 Reduction SHALL use 3:2 CSA levels: each level groups rows in threes, passes the 1 or 2 leftover rows through unchanged, and repeats until 2 rows remain; L is the level count (13 rows -> 9 -> 6 -> 4 -> 3 -> 2, so L=5).
REQ-019 Every CSA carry SHALL be shifted left one bit with a zero LSB before reuse; the shifted-out bit [C_WIDTH-1] SHALL be ORed into the operation's MSB_cor flag.
REQ-020 Arithmetic SHALL satisfy (Pp_sum_DO + Pp_carry_DO) mod 2^C_WIDTH == (sum of all Pp_index_DI) mod 2^C_WIDTH.
REQ-021 Pipeline registers SHALL be placed after level ceil(k*L/C_PIPE_STAGES) for k=1..C_PIPE_STAGES; the last register drives the outputs.
REQ-022 Each stage register SHALL hold the stage's rows, a valid bit, the tag and the accumulated MSB_cor flag.
REQ-023 Latency SHALL be exactly C_PIPE_STAGES cycles from an accepted input to Out_valid_SO when no stall occurs; sustained throughput SHALL be one operation per cycle.
REQ-024 Stage k SHALL load when it is empty or the stage after it advances; the output stage advances when Out_ready_SI=1 (bubble-collapsing).
REQ-025 In_ready_SO SHALL equal the load condition of stage 1 AND NOT Flush_SI; an input is accepted when In_valid_SI and In_ready_SO are both 1.
REQ-026 While Out_valid_SO=1 and Out_ready_SI=0, all outputs SHALL hold stable.
REQ-027 When Flush_SI=1, every stage valid bit SHALL clear at the next edge, and no input SHALL be accepted that cycle.
REQ-028 Operations SHALL leave in acceptance order, with no loss or duplication except through flush or reset.
REQ-029 Data registers MAY be left unloaded while their valid bit is 0.

Reset
REQ-030 When Rst_RBI=0, all valid bits, data, tags and MSB flags SHALL clear asynchronously: Out_valid_SO=0, Pp_sum_DO=0, Pp_carry_DO=0, MSB_cor_DO=0, Tag_DO=0.
REQ-031 In_ready_SO SHALL be 1 on the first cycle after reset deasserts.
REQ-032 Asserting reset mid-operation SHALL discard all in-flight operations, and none SHALL appear after release.

Verification
REQ-033 Defaults, Out_ready_SI=1, all 13 PP=1, tag=3 -> Out_valid_SO two cycles later, sum+carry=13, MSB_cor_DO=0, Tag_DO=3.
REQ-034 Five back-to-back inputs with PP[0]=i and all other PP=0, tags 0..4 -> five consecutive output cycles with sum+carry=0..4 in order, and In_ready_SO held at 1.
REQ-035 Out_ready_SI=0 with continuous inputs -> exactly C_PIPE_STAGES accepted, then In_ready_SO=0 and outputs stable; release Out_ready_SI -> drain in order with no loss.
REQ-036 C_NUM_PP=3, C_PIPE_STAGES=1, all PP=2^(C_WIDTH-1) -> Pp_sum_DO=2^(C_WIDTH-1), Pp_carry_DO=0, MSB_cor_DO=1.
REQ-037 Flush_SI pulsed with 2 operations in flight and In_valid_SI=1 -> Out_valid_SO=0 next cycle, flushed and flush-cycle inputs never appear, next input has normal latency.
REQ-038 Rst_RBI asserted asynchronously between clock edges with operations in flight -> outputs zero immediately, and none emerge after release.
